// File: rtl/ram_wrbuf.sv
// Write buffer in front of a RAM write port: FIFO of pending writes with read-forwarding.
// Optional write coalescing into the youngest slot is enabled by defining WRBUF_COALESCE_EN.
module ram_wrbuf #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned WIDTH   = 68,
  parameter int unsigned ENTRIES = 4,
  localparam int unsigned BEW    = (WIDTH - 1) / 8 + 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [AW-1:0]    ReqAdr,
  input  logic [WIDTH-1:0] ReqData,
  input  logic [BEW-1:0]   ReqBE,
  input  logic             DrainStall,
  output logic             ce2,
  output logic             we2,
  output logic [AW-1:0]    wa2,
  output logic [WIDTH-1:0] wd2,
  output logic [BEW-1:0]   bwe2,
  input  logic [AW-1:0]    RdAdr,
  output logic [BEW-1:0]   FwdBE,
  output logic [WIDTH-1:0] FwdData,
  output logic             Empty
);

  localparam int unsigned PW = $clog2(ENTRIES);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]      adr_q  [ENTRIES];
  logic [WIDTH-1:0]   data_q [ENTRIES];
  logic [BEW-1:0]     be_q   [ENTRIES];
  logic [ENTRIES-1:0] vld_q;
  logic [PW-1:0]      head_q, tail_q, young, idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               drain, coalesce_hit, push, alloc, merge;
  logic [WIDTH-1:0]   merge_data;

  assign young = tail_q - 1'b1;
  assign drain = (cnt_q != '0) & ~DrainStall;

`ifdef WRBUF_COALESCE_EN
  // Never merge into a slot that is leaving the buffer on this very edge.
  assign coalesce_hit = ReqValid & (cnt_q != '0) & (ReqAdr == adr_q[young]) &
                        ~(drain & (cnt_q == CW'(1)));
`else
  assign coalesce_hit = 1'b0;
`endif

  assign ReqReady = (cnt_q < CW'(ENTRIES)) | coalesce_hit;
  assign push     = ReqValid & ReqReady;
  assign alloc    = push & ~coalesce_hit;
  assign merge    = push & coalesce_hit;

  assign ce2   = drain;
  assign we2   = drain;
  assign wa2   = adr_q[head_q];
  assign wd2   = data_q[head_q];
  assign bwe2  = be_q[head_q];
  assign Empty = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (alloc && !drain) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!alloc && drain) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    merge_data = data_q[young];
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (ReqBE[b/8]) merge_data[b] = ReqData[b];
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier bytes.
  always_comb begin
    FwdBE   = '0;
    FwdData = '0;
    idx     = head_q;
    for (int k = 0; k < int'(ENTRIES); k++) begin
      idx = head_q + PW'(k);
      if (vld_q[idx] && (adr_q[idx] == RdAdr)) begin
        FwdBE = FwdBE | be_q[idx];
        for (int b = 0; b < int'(WIDTH); b++) begin
          if (be_q[idx][b/8]) FwdData[b] = data_q[idx][b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (drain) begin
        vld_q[head_q] <= 1'b0;
        be_q[head_q]  <= '0;
        head_q        <= head_q + 1'b1;
      end
      // Head and tail only alias when empty or full, so a pop and an allocation never collide.
      if (alloc) begin
        adr_q[tail_q]  <= ReqAdr;
        data_q[tail_q] <= ReqData;
        be_q[tail_q]   <= ReqBE;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      if (merge) begin
        data_q[young] <= merge_data;
        be_q[young]   <= be_q[young] | ReqBE;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_wrbuf.sv
// Scoreboard bench for ram_wrbuf: expected RAM writes are queued by the stimulus and
// checked in order by a monitor whenever we2 is seen.
module tb_ram_wrbuf;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ENTRIES = 4;
  localparam int unsigned BEW     = 4;
  localparam int unsigned AW      = 10;

  logic             clk, reset, ReqValid, ReqReady, DrainStall;
  logic [AW-1:0]    ReqAdr, wa2, RdAdr;
  logic [WIDTH-1:0] ReqData, wd2, FwdData;
  logic [BEW-1:0]   ReqBE, bwe2, FwdBE;
  logic             ce2, we2, Empty;

  typedef struct packed {
    logic [AW-1:0]    adr;
    logic [WIDTH-1:0] data;
    logic [BEW-1:0]   be;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  ram_wrbuf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAdr(ReqAdr),
    .ReqData(ReqData), .ReqBE(ReqBE), .DrainStall(DrainStall), .ce2(ce2), .we2(we2),
    .wa2(wa2), .wd2(wd2), .bwe2(bwe2), .RdAdr(RdAdr), .FwdBE(FwdBE), .FwdData(FwdData),
    .Empty(Empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && we2 === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adr %0h data %0h be %0h, want no write",
                 wa2, wd2, bwe2);
      end else begin
        e = exp_q.pop_front();
        check("ce2", {63'd0, ce2}, 64'd1);
        check("wa2", {54'd0, wa2}, {54'd0, e.adr});
        check("wd2", {32'd0, wd2}, {32'd0, e.data});
        check("bwe2", {60'd0, bwe2}, {60'd0, e.be});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input logic [BEW-1:0] be);
    exp_q.push_back('{adr: a, data: d, be: be});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [BEW-1:0] be);
    int n;
    ReqValid = 1'b1;
    ReqAdr   = a;
    ReqData  = d;
    ReqBE    = be;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ReqReady) break;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ReqReady 0 want 1 (adr %0h)", a);
    end
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (Empty) break;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got Empty 0 want 1");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ReqValid = 1'b0; ReqAdr = '0; ReqData = '0; ReqBE = '0;
    DrainStall = 1'b0; RdAdr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", {63'd0, ReqReady}, 64'd1);
    check("rst_we2", {63'd0, we2}, 64'd0);
    check("rst_ce2", {63'd0, ce2}, 64'd0);
    check("rst_bwe2", {60'd0, bwe2}, 64'd0);
    check("rst_fwdbe", {60'd0, FwdBE}, 64'd0);
    check("rst_fwddata", {32'd0, FwdData}, 64'd0);
    check("rst_empty", {63'd0, Empty}, 64'd1);
    @(posedge clk); #1;

    // Single write drains the cycle after acceptance
    exp_wr(10'd5, 32'h11223344, 4'hF);
    push(10'd5, 32'h11223344, 4'hF);
    @(negedge clk);
    check("single_we2", {63'd0, we2}, 64'd1);
    check("single_busy", {63'd0, Empty}, 64'd0);
    @(negedge clk);
    check("single_empty", {63'd0, Empty}, 64'd1);
    check("single_idle", {63'd0, we2}, 64'd0);
    @(posedge clk); #1;

    // Stalled fill, fifth request refused, drain in order
    DrainStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_wr(10'(10 + i), 32'hA0A00000 + 32'(i), 4'hF);
      push(10'(10 + i), 32'hA0A00000 + 32'(i), 4'hF);
    end
    ReqValid = 1'b1; ReqAdr = 10'd14; ReqData = 32'h5; ReqBE = 4'hF;
    @(negedge clk);
    check("full_refuse", {63'd0, ReqReady}, 64'd0);
    @(posedge clk); #1;
    ReqValid = 1'b0;
    DrainStall = 1'b0;
    wait_empty();
    check("after_drain_ready", {63'd0, ReqReady}, 64'd1);
    check("order_drained", 64'(exp_q.size()), 64'd0);

    // Forwarding merges bytes, youngest wins
    DrainStall = 1'b1;
`ifdef WRBUF_COALESCE_EN
    exp_wr(10'd9, 32'h00BBBBAA, 4'h7);
`else
    exp_wr(10'd9, 32'h0000AAAA, 4'h3);
    exp_wr(10'd9, 32'h00BBBB00, 4'h6);
`endif
    push(10'd9, 32'h0000AAAA, 4'h3);
    push(10'd9, 32'h00BBBB00, 4'h6);
    RdAdr = 10'd9; #1;
    check("fwd_be", {60'd0, FwdBE}, 64'h7);
    check("fwd_data", {32'd0, FwdData}, 64'h00BBBBAA);
    RdAdr = 10'd8; #1;
    check("fwd_miss_be", {60'd0, FwdBE}, 64'h0);
    check("fwd_miss_data", {32'd0, FwdData}, 64'h0);
    DrainStall = 1'b0;
    wait_empty();

    // Zero byte-enable still writes
    exp_wr(10'd20, 32'hDEADBEEF, 4'h0);
    push(10'd20, 32'hDEADBEEF, 4'h0);
    wait_empty();

    // Full with drain in progress: no push-through, accepted next cycle
    DrainStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_wr(10'(30 + i), 32'hC0000000 + 32'(i), 4'hF);
      push(10'(30 + i), 32'hC0000000 + 32'(i), 4'hF);
    end
    exp_wr(10'd34, 32'hC0000004, 4'hF);
    ReqValid = 1'b1; ReqAdr = 10'd34; ReqData = 32'hC0000004; ReqBE = 4'hF;
    DrainStall = 1'b0;
    @(negedge clk);
    check("no_pushthrough", {63'd0, ReqReady}, 64'd0);
    @(posedge clk); #1;
    DrainStall = 1'b1;
    @(negedge clk);
    check("refill_ready", {63'd0, ReqReady}, 64'd1);
    @(posedge clk); #1;
    ReqValid = 1'b0;
    check("refilled_full", {63'd0, ReqReady}, 64'd0);
    check("refilled_busy", {63'd0, Empty}, 64'd0);
    DrainStall = 1'b0;
    wait_empty();

    // Reset discards buffered writes
    DrainStall = 1'b1;
    push(10'd40, 32'h40404040, 4'hF);
    push(10'd41, 32'h41414141, 4'hF);
    push(10'd42, 32'h42424242, 4'hF);
    RdAdr = 10'd41; #1;
    check("pre_rst_fwd", {60'd0, FwdBE}, 64'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    DrainStall = 1'b0;
    @(negedge clk);
    check("post_rst_empty", {63'd0, Empty}, 64'd1);
    check("post_rst_we2", {63'd0, we2}, 64'd0);
    check("post_rst_fwdbe", {60'd0, FwdBE}, 64'd0);
    check("post_rst_fwddata", {32'd0, FwdData}, 64'd0);
    check("post_rst_ready", {63'd0, ReqReady}, 64'd1);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;

    // Same-address requests: merged when coalescing, separate slots otherwise
    DrainStall = 1'b1;
`ifdef WRBUF_COALESCE_EN
    exp_wr(10'd3, 32'hB20000A1, 4'h9);
`else
    exp_wr(10'd3, 32'h000000A1, 4'h1);
    exp_wr(10'd3, 32'hB2000000, 4'h8);
`endif
    push(10'd3, 32'h000000A1, 4'h1);
    push(10'd3, 32'hB2000000, 4'h8);
    RdAdr = 10'd3; #1;
    check("same_adr_fwdbe", {60'd0, FwdBE}, 64'h9);
    check("same_adr_fwddata", {32'd0, FwdData}, 64'hB20000A1);
    DrainStall = 1'b0;
    wait_empty();
    repeat (2) @(posedge clk);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
